prog_clk_divider: RTL and testbench

Runtime-programmable integer clock divider producing a 50%-duty output for any divide ratio N >= 2, even or odd, from a single input clock. It generalises the fixed even/odd dividers into one block. It adds a loadable divisor, applied glitch-free at output-period boundaries, and an enable that stops the clock cleanly. A period-start tick is provided for synchronous logic in the clk_in domain.

---
 rtl/prog_clk_divider_if.sv | 24 ++
 rtl/prog_clk_divider.sv | 103 ++++++++++
 tb/tb_prog_clk_divider.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_clk_divider_if.sv
// Control/status bundle for the programmable clock divider.
// The master side drives run enable and divisor loads; the slave side returns the clock and status.
interface prog_clk_divider_if #(
    parameter int unsigned DIV_W = 8
);
    logic             en;
    logic [DIV_W-1:0] div_val;
    logic             div_load;
    logic             clk_out;
    logic             tick;
    logic [DIV_W-1:0] div_active;
    logic             pending;
    logic             load_err;

    modport master (
        output en, div_val, div_load,
        input  clk_out, tick, div_active, pending, load_err
    );

    modport slave (
        input  en, div_val, div_load,
        output clk_out, tick, div_active, pending, load_err
    );
endinterface

// File: rtl/prog_clk_divider.sv
// Runtime-programmable 50%-duty integer clock divider (N >= 2, even or odd).
// Divisor changes take effect only at output-period boundaries; en stops the clock cleanly.
module prog_clk_divider #(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DIV_DEFAULT = 4
) (
    input logic               clk_in,
    input logic               rst_n,
    prog_clk_divider_if.slave bus_if
);
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_DEFAULT);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] div_active_q;
    logic [DIV_W-1:0] pend_val_q;
    logic             pending_q;
    logic             hi_q;
    logic             neg_q;
    logic             tick_q;
    logic             load_err_q;
    logic             load_ok;
    logic             wrap;
    logic             fall;

    assign load_ok = bus_if.div_load && (bus_if.div_val >= DIV_W'(2));
    assign cnt_d   = cnt_q + 1'b1;
    assign wrap    = (cnt_q == div_active_q - 1'b1);
    // N>>1 is N/2 for even N and (N-1)/2 for odd N; odd N gets its extra half cycle from neg_q
    assign fall    = (cnt_d == (div_active_q >> 1));

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            div_active_q <= DIV_RST;
            pend_val_q   <= '0;
            pending_q    <= 1'b0;
            hi_q         <= 1'b0;
            tick_q       <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            tick_q     <= 1'b0;
            load_err_q <= bus_if.div_load && !load_ok;
            case (state_q)
                IDLE: begin
                    if (load_ok) begin
                        div_active_q <= bus_if.div_val;
                    end
                    if (bus_if.en) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        hi_q    <= 1'b1;
                        tick_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (wrap) begin
                        cnt_q <= '0;
                        if (pending_q) begin
                            div_active_q <= pend_val_q;
                            pending_q    <= 1'b0;
                        end
                        if (bus_if.en) begin
                            hi_q   <= 1'b1;
                            tick_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                        if (fall) begin
                            hi_q <= 1'b0;
                        end
                    end
                    // A load on the boundary edge itself waits for the following boundary
                    if (load_ok) begin
                        pend_val_q <= bus_if.div_val;
                        pending_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(negedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= hi_q & div_active_q[0];
        end
    end

    assign bus_if.clk_out    = hi_q | neg_q;
    assign bus_if.tick       = tick_q;
    assign bus_if.div_active = div_active_q;
    assign bus_if.pending    = pending_q;
    assign bus_if.load_err   = load_err_q;
endmodule

// File: tb/tb_prog_clk_divider.sv
// Bench for prog_clk_divider: half-cycle waveform reference model (period = 2N half steps,
// high for the first N), compared at both clock phases after every posedge.
module tb_prog_clk_divider;
    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;

    prog_clk_divider_if #(.DIV_W(8)) bus ();

    prog_clk_divider #(.DIV_W(8), .DIV_DEFAULT(4)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus_if (bus)
    );

    always #10 clk_in = ~clk_in;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: running flag, posedges into current period, divisor, pending load
    bit m_run;
    int m_p;
    int m_n;
    bit m_pend;
    int m_pv;
    bit m_err;

    task automatic model_reset();
        m_run = 0; m_p = 0; m_n = 4; m_pend = 0; m_pv = 0; m_err = 0;
    endtask

    task automatic model_pos(input bit e, input bit ld, input int v);
        bit ok;
        ok    = ld && (v >= 2);
        m_err = ld && !ok;
        if (m_run) begin
            m_p++;
            if (m_p == m_n) begin
                if (m_pend) begin
                    m_n    = m_pv;
                    m_pend = 0;
                end
                m_p = 0;
                if (!e) m_run = 0;
            end
            if (ok) begin
                m_pend = 1;
                m_pv   = v;
            end
        end else begin
            if (ok) m_n = v;
            if (e) begin
                m_run = 1;
                m_p   = 0;
            end
        end
    endtask

    function automatic logic [11:0] expv(input int h);
        logic c, t;
        c = m_run && ((2 * m_p + h) < m_n);
        t = m_run && (m_p == 0);
        return {c, t, m_pend, m_err, 8'(m_n)};
    endfunction

    function automatic logic [11:0] obs();
        return {bus.clk_out, bus.tick, bus.pending, bus.load_err, bus.div_active};
    endfunction

    // Drive one clk_in cycle of inputs; return observed/expected at posedge+2 and negedge+2
    task automatic step(input bit e, input bit ld, input int v,
                        output logic [23:0] o, output logic [23:0] x);
        logic [11:0] op, xp;
        bus.en = e; bus.div_load = ld; bus.div_val = 8'(v);
        @(posedge clk_in);
        if (!rst_n) model_reset();
        else        model_pos(e, ld, v);
        #2;
        op = obs(); xp = expv(0);
        @(negedge clk_in);
        #2;
        o = {op, obs()};
        x = {xp, expv(1)};
    endtask

    logic [23:0] o, x;

    task automatic test_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'($urandom % 2), int'($urandom % 10), o, x);
            n_chk++;
            if (o !== x) $display("FAIL reset_hold step %0d: got %h want %h", i, o, x);
            else n_pass++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 0, o, x);
            n_chk++;
            if (o !== x) $display("FAIL reset_release step %0d: got %h want %h", i, o, x);
            else n_pass++;
        end
    endtask

    task automatic test_even();
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 1'b0, 0, o, x);
            n_chk++;
            if (o !== x) $display("FAIL even_n4 step %0d: got %h want %h", i, o, x);
            else n_pass++;
        end
    endtask

    task automatic stop_run(input string nm);
        int guard = 0;
        while (m_run && guard < 300) begin
            step(1'b0, 1'b0, 0, o, x);
            guard++;
            n_chk++;
            if (o !== x) $display("FAIL %s_stop step %0d: got %h want %h", nm, guard, o, x);
            else n_pass++;
        end
        if (m_run) begin
            n_chk++;
            $display("FAIL %s_stop: still running after %0d cycles, want idle", nm, guard);
        end
    endtask

    task automatic test_odd();
        int nv [2] = '{3, 5};
        foreach (nv[k]) begin
            stop_run("odd");
            step(1'b0, 1'b1, nv[k], o, x);
            n_chk++;
            if (o !== x) $display("FAIL odd_idle_load n=%0d: got %h want %h", nv[k], o, x);
            else n_pass++;
            for (int i = 0; i < 4 * nv[k] + 1; i++) begin
                step(1'b1, 1'b0, 0, o, x);
                n_chk++;
                if (o !== x) $display("FAIL odd_run n=%0d step %0d: got %h want %h", nv[k], i, o, x);
                else n_pass++;
            end
        end
    endtask

    task automatic test_runtime_change();
        stop_run("chg");
        step(1'b0, 1'b1, 4, o, x);
        step(1'b1, 1'b0, 0, o, x);
        step(1'b1, 1'b1, 5, o, x);
        n_chk++;
        if (o !== x) $display("FAIL chg_load_high: got %h want %h", o, x);
        else n_pass++;
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 1'b0, 0, o, x);
            n_chk++;
            if (o !== x) $display("FAIL chg_run step %0d: got %h want %h", i, o, x);
            else n_pass++;
        end
    endtask

    task automatic test_invalid_overwrite();
        int guard = 0;
        step(1'b1, 1'b1, int'($urandom % 2), o, x);
        n_chk++;
        if (o !== x) $display("FAIL invalid_load: got %h want %h", o, x);
        else n_pass++;
        while (m_p != 0 && guard < 300) begin
            step(1'b1, 1'b0, 0, o, x);
            guard++;
        end
        step(1'b1, 1'b1, 6, o, x);
        step(1'b1, 1'b1, 7, o, x);
        n_chk++;
        if (o !== x) $display("FAIL overwrite_load: got %h want %h", o, x);
        else n_pass++;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b0, 0, o, x);
            n_chk++;
            if (o !== x) $display("FAIL overwrite_run step %0d: got %h want %h", i, o, x);
            else n_pass++;
        end
    endtask

    task automatic test_enable();
        int guard = 0;
        while (m_p != 0 && guard < 300) begin
            step(1'b1, 1'b0, 0, o, x);
            guard++;
        end
        for (int i = 0; i < m_n + 6; i++) begin
            step(1'b0, 1'b0, 0, o, x);
            n_chk++;
            if (o !== x) $display("FAIL en_low step %0d: got %h want %h", i, o, x);
            else n_pass++;
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 0, o, x);
            n_chk++;
            if (o !== x) $display("FAIL en_restart step %0d: got %h want %h", i, o, x);
            else n_pass++;
        end
        // Brief drop of en mid-period must not stop the clock
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 0, o, x);
            if (i == 1) step(1'b0, 1'b0, 0, o, x);
            n_chk++;
            if (o !== x) $display("FAIL en_blip step %0d: got %h want %h", i, o, x);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        while (m_p != m_n - 1 && guard < 300) begin
            step(1'b1, 1'b0, 0, o, x);
            guard++;
        end
        step(1'b1, 1'b0, 0, o, x);
        step(1'b1, 1'b1, 7, o, x);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_chk++;
        if (obs() !== expv(0)) $display("FAIL reset_async: got %h want %h", obs(), expv(0));
        else n_pass++;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, o, x);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 0, o, x);
            n_chk++;
            if (o !== x) $display("FAIL reset_mid_run step %0d: got %h want %h", i, o, x);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        bit e, ld;
        int v;
        for (int i = 0; i < 800; i++) begin
            e  = ($urandom % 10) != 0;
            ld = ($urandom % 7) == 0;
            v  = int'($urandom % 12);
            step(e, ld, v, o, x);
            n_chk++;
            if (o !== x) $display("FAIL random step %0d: got %h want %h", i, o, x);
            else n_pass++;
        end
    endtask

    initial begin
        bus.en = 1'b0; bus.div_load = 1'b0; bus.div_val = '0;
        model_reset();
        test_reset();
        test_even();
        test_odd();
        test_runtime_change();
        test_invalid_overwrite();
        test_enable();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
